// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 default timing constants, total helper and sync bus type
package vga_timing_pkg;

  localparam int H_ACTIVE_640 = 640;
  localparam int H_FP_640     = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BP_640     = 48;
  localparam int V_ACTIVE_480 = 480;
  localparam int V_FP_480     = 10;
  localparam int V_SYNC_480   = 2;
  localparam int V_BP_480     = 33;

  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } sync_bus_t;

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - DEPTH-stage register pipe for the sync bus, reset loads RST_VAL
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int        DEPTH   = 1,
  parameter sync_bus_t RST_VAL = '0
) (
  input  logic      clk,
  input  logic      resetn,
  input  sync_bus_t d,
  output sync_bus_t q
);

  sync_bus_t stages [DEPTH];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= RST_VAL;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator with delayed syncs and strobes
// VGA_FRAME_CNT_EN adds the 8-bit frame_cnt output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_640,
  parameter int H_FP     = H_FP_640,
  parameter int H_SYNC   = H_SYNC_640,
  parameter int H_BP     = H_BP_640,
  parameter int V_ACTIVE = V_ACTIVE_480,
  parameter int V_FP     = V_FP_480,
  parameter int V_SYNC   = V_SYNC_480,
  parameter int V_BP     = V_BP_480,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 0,
  parameter int CW       = 10
) (
  input  logic          pixel_clk,
  input  logic          reset_rtl_0,
  output logic          hs,
  output logic          vs,
  output logic          active_nblank,
  output logic [CW-1:0] drawX,
  output logic [CW-1:0] drawY,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_tick
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]    frame_cnt
`endif
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] VBLANK_Y   = CW'(V_ACTIVE);

  localparam sync_bus_t SYNC_IDLE = '{hs: !HS_POL, vs: !VS_POL, act: 1'b0};

  if ((H_TOTAL - 1 > (1 << CW) - 1) || (V_TOTAL - 1 > (1 << CW) - 1)) begin : g_bad_cw
    $error("vga_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits");
  end
  if ((PIPE_DLY < 0) || (PIPE_DLY > 7)) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be 0..7");
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_rtl_0) begin
      drawX <= '0;
      drawY <= '0;
    end else if (drawX == H_LAST) begin
      drawX <= '0;
      drawY <= (drawY == V_LAST) ? '0 : drawY + 1'b1;
    end else begin
      drawX <= drawX + 1'b1;
    end
  end

  // Strobes are held low during reset so game logic never sees a spurious update.
  assign line_start  = reset_rtl_0 && (drawX == '0);
  assign frame_start = line_start && (drawY == '0);
  assign vblank_tick = line_start && (drawY == VBLANK_Y);

  logic      hs_raw, vs_raw, act_raw;
  sync_bus_t raw, dly;

  assign hs_raw  = ((drawX >= HS_FIRST) && (drawX <= HS_LAST)) ? HS_POL : !HS_POL;
  assign vs_raw  = ((drawY >= VS_FIRST) && (drawY <= VS_LAST)) ? VS_POL : !VS_POL;
  assign act_raw = (drawX <= H_ACT_LAST) && (drawY <= V_ACT_LAST);
  assign raw     = '{hs: hs_raw, vs: vs_raw, act: act_raw};

  sync_delay_line #(
    .DEPTH   (PIPE_DLY + 1),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .clk    (pixel_clk),
    .resetn (reset_rtl_0),
    .d      (raw),
    .q      (dly)
  );

  assign hs            = dly.hs;
  assign vs            = dly.vs;
  assign active_nblank = dly.act;

`ifdef VGA_FRAME_CNT_EN
  // The frame_start right after reset opens the first frame; only later ones close a frame.
  logic frame_open;

  always_ff @(posedge pixel_clk) begin
    if (!reset_rtl_0) begin
      frame_cnt  <= '0;
      frame_open <= 1'b0;
    end else begin
      frame_open <= 1'b1;
      if (frame_start && frame_open) frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench: arithmetic timing model plus directed literal checks
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn    = 1'b0;
  logic rstn_sm = 1'b0;

  int checks   = 0;
  int failures = 0;
  int n_main   = 0;
  int n_sm     = 0;
  bit ir_main  = 1'b1;
  bit ir_sm    = 1'b1;

  typedef struct {
    int x; int y; int hs; int vs; int act; int ls; int fs; int vt; int fc;
  } exp_t;

  logic       def_hs, def_vs, def_act, def_ls, def_fs, def_vt;
  logic [9:0] def_x, def_y;
  logic [7:0] def_fc;
  logic       p2_hs, p2_vs, p2_act, p2_ls, p2_fs, p2_vt;
  logic [9:0] p2_x, p2_y;
  logic [7:0] p2_fc;
  logic       sm_hs, sm_vs, sm_act, sm_ls, sm_fs, sm_vt;
  logic [3:0] sm_x, sm_y;
  logic [7:0] sm_fc;
  logic       md_hs, md_vs, md_act, md_ls, md_fs, md_vt;
  logic [4:0] md_x, md_y;
  logic [7:0] md_fc;

  vga_timing_gen u_def (
    .pixel_clk(clk), .reset_rtl_0(rstn), .hs(def_hs), .vs(def_vs), .active_nblank(def_act),
    .drawX(def_x), .drawY(def_y), .line_start(def_ls), .frame_start(def_fs), .vblank_tick(def_vt)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(def_fc)
`endif
  );

  vga_timing_gen #(.PIPE_DLY(2)) u_p2 (
    .pixel_clk(clk), .reset_rtl_0(rstn), .hs(p2_hs), .vs(p2_vs), .active_nblank(p2_act),
    .drawX(p2_x), .drawY(p2_y), .line_start(p2_ls), .frame_start(p2_fs), .vblank_tick(p2_vt)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(p2_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CW(4), .HS_POL(1)
  ) u_sm (
    .pixel_clk(clk), .reset_rtl_0(rstn_sm), .hs(sm_hs), .vs(sm_vs), .active_nblank(sm_act),
    .drawX(sm_x), .drawY(sm_y), .line_start(sm_ls), .frame_start(sm_fs), .vblank_tick(sm_vt)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(sm_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(5), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .CW(5), .VS_POL(1), .PIPE_DLY(3)
  ) u_md (
    .pixel_clk(clk), .reset_rtl_0(rstn), .hs(md_hs), .vs(md_vs), .active_nblank(md_act),
    .drawX(md_x), .drawY(md_y), .line_start(md_ls), .frame_start(md_fs), .vblank_tick(md_vt)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(md_fc)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign def_fc = '0;
  assign p2_fc  = '0;
  assign sm_fc  = '0;
  assign md_fc  = '0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle n counts pixel clocks since the first edge with reset released.
  function automatic exp_t model(input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input int hp, input int vp, input int dly, input int n);
    exp_t e;
    int ht, vt, m, xm, ym;
    ht   = ha + hf + hsw + hb;
    vt   = va + vf + vsw + vb;
    e.x  = n % ht;
    e.y  = (n / ht) % vt;
    e.ls = (e.x == 0) ? 1 : 0;
    e.fs = (e.ls == 1 && e.y == 0) ? 1 : 0;
    e.vt = (e.ls == 1 && e.y == va) ? 1 : 0;
    m    = n - dly - 1;
    if (m < 0) begin
      e.hs  = 1 - hp;
      e.vs  = 1 - vp;
      e.act = 0;
    end else begin
      xm    = m % ht;
      ym    = (m / ht) % vt;
      e.hs  = (xm >= ha + hf && xm < ha + hf + hsw) ? hp : 1 - hp;
      e.vs  = (ym >= va + vf && ym < va + vf + vsw) ? vp : 1 - vp;
      e.act = (xm < ha && ym < va) ? 1 : 0;
    end
    e.fc = (n == 0) ? 0 : ((n - 1) / (ht * vt)) % 256;
    return e;
  endfunction

  task automatic cmp(input string tag, input int ha, input int hf, input int hsw, input int hb,
                     input int va, input int vf, input int vsw, input int vb,
                     input int hp, input int vp, input int dly, input int n, input bit rst_state,
                     input logic [31:0] x, input logic [31:0] y, input logic [31:0] h,
                     input logic [31:0] v, input logic [31:0] a, input logic [31:0] ls,
                     input logic [31:0] fs, input logic [31:0] vt, input logic [31:0] fc);
    exp_t e;
    if (rst_state) begin
      e.x = 0; e.y = 0; e.hs = 1 - hp; e.vs = 1 - vp; e.act = 0;
      e.ls = 0; e.fs = 0; e.vt = 0; e.fc = 0;
    end else begin
      e = model(ha, hf, hsw, hb, va, vf, vsw, vb, hp, vp, dly, n);
    end
    chk({tag, ".drawX"}, x, e.x);
    chk({tag, ".drawY"}, y, e.y);
    chk({tag, ".hs"}, h, e.hs);
    chk({tag, ".vs"}, v, e.vs);
    chk({tag, ".active_nblank"}, a, e.act);
    chk({tag, ".line_start"}, ls, e.ls);
    chk({tag, ".frame_start"}, fs, e.fs);
    chk({tag, ".vblank_tick"}, vt, e.vt);
`ifdef VGA_FRAME_CNT_EN
    chk({tag, ".frame_cnt"}, fc, e.fc);
`endif
  endtask

  task automatic compare_all();
    bit rs_main, rs_sm;
    rs_main = ir_main && !rstn;
    rs_sm   = ir_sm && !rstn_sm;
    cmp("def", 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 0, n_main, rs_main,
        32'(def_x), 32'(def_y), 32'(def_hs), 32'(def_vs), 32'(def_act),
        32'(def_ls), 32'(def_fs), 32'(def_vt), 32'(def_fc));
    cmp("p2", 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, n_main, rs_main,
        32'(p2_x), 32'(p2_y), 32'(p2_hs), 32'(p2_vs), 32'(p2_act),
        32'(p2_ls), 32'(p2_fs), 32'(p2_vt), 32'(p2_fc));
    cmp("sm", 8, 1, 2, 1, 4, 1, 1, 1, 1, 0, 0, n_sm, rs_sm,
        32'(sm_x), 32'(sm_y), 32'(sm_hs), 32'(sm_vs), 32'(sm_act),
        32'(sm_ls), 32'(sm_fs), 32'(sm_vt), 32'(sm_fc));
    cmp("md", 6, 2, 3, 2, 5, 2, 2, 1, 0, 1, 3, n_main, rs_main,
        32'(md_x), 32'(md_y), 32'(md_hs), 32'(md_vs), 32'(md_act),
        32'(md_ls), 32'(md_fs), 32'(md_vt), 32'(md_fc));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rstn) begin n_main = 0; ir_main = 1'b1; end
    else begin n_main++; ir_main = 1'b0; end
    if (!rstn_sm) begin n_sm = 0; ir_sm = 1'b1; end
    else begin n_sm++; ir_sm = 1'b0; end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int hs_low, first_low_x, p2_act_x, p2_act_y, p2_hs_x, prev_x, wrap_ls, wrap_prev;
    int vt_cnt, vt_y, vs_low;
    bit found;
    hs_low = 0; first_low_x = -1; p2_act_x = -1; p2_act_y = -1; p2_hs_x = -1;
    prev_x = 0; wrap_ls = -1; wrap_prev = -1; vt_cnt = 0; vt_y = -1; vs_low = 0; found = 1'b0;

    repeat (3) tick();
    chk("t1_rst_frame_start", 32'(def_fs), 0);
    chk("t1_rst_hs", 32'(def_hs), 1);

    rstn    = 1'b1;
    rstn_sm = 1'b1;
    #1;
    chk("t1_c0_drawX", 32'(def_x), 0);
    chk("t1_c0_drawY", 32'(def_y), 0);
    chk("t1_c0_frame_start", 32'(def_fs), 1);
    chk("t1_c0_hs", 32'(def_hs), 1);
    chk("t1_c0_vs", 32'(def_vs), 1);
    chk("t1_c0_active", 32'(def_act), 0);

    tick();
    chk("t1_c1_active", 32'(def_act), 1);
    chk("t4_c1_p2_active", 32'(p2_act), 0);

    for (int i = 0; i < 800; i++) begin
      prev_x = int'(def_x);
      tick();
      if (!def_hs) begin
        hs_low++;
        if (first_low_x < 0) first_low_x = int'(def_x);
      end
      if (p2_act && p2_act_x < 0) begin p2_act_x = int'(p2_x); p2_act_y = int'(p2_y); end
      if (!p2_hs && p2_hs_x < 0) p2_hs_x = int'(p2_x);
      if (def_x == 10'd0 && def_y == 10'd1) begin wrap_ls = int'(def_ls); wrap_prev = prev_x; end
    end
    chk("t2_hs_low_cycles", 32'(hs_low), 96);
    chk("t2_hs_first_low_x", 32'(first_low_x), 657);
    chk("t2_wrap_prev_x", 32'(wrap_prev), 799);
    chk("t2_wrap_line_start", 32'(wrap_ls), 1);
    chk("t4_p2_active_rise_x", 32'(p2_act_x), 3);
    chk("t4_p2_active_rise_y", 32'(p2_act_y), 0);
    chk("t4_p2_hs_fall_x", 32'(p2_hs_x), 659);

    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (sm_x == 4'd5 && sm_y == 4'd2) found = 1'b1;
    end
    chk("t5_reset_point_reached", 32'(found), 1);
    rstn_sm = 1'b0;
    tick();
    chk("t5_rst_drawX", 32'(sm_x), 0);
    chk("t5_rst_drawY", 32'(sm_y), 0);
    chk("t5_rst_hs", 32'(sm_hs), 0);
    chk("t5_rst_line_start", 32'(sm_ls), 0);
    tick();
    rstn_sm = 1'b1;
    #1;
    chk("t5_rel_frame_start", 32'(sm_fs), 1);
    chk("t5_rel_hs", 32'(sm_hs), 0);

    for (int i = 0; i < 84; i++) begin
      tick();
      if (sm_vt) begin vt_cnt++; vt_y = int'(sm_y); end
      if (!sm_vs) vs_low++;
    end
    chk("t3_vblank_count", 32'(vt_cnt), 1);
    chk("t3_vblank_line", 32'(vt_y), 4);
    chk("t3_vs_low_cycles", 32'(vs_low), 12);
    chk("t3_wrap_frame_start", 32'(sm_fs), 1);
    chk("t3_wrap_drawY", 32'(sm_y), 0);

    for (int i = 0; i < 257 * 84 + 1 - 84; i++) tick();
`ifdef VGA_FRAME_CNT_EN
    chk("t6_frame_cnt_257", 32'(sm_fc), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA sync generator that feeds hdmi_tx_0 and the colour/background mappers.
- Timing (active/porch/sync per axis), sync polarity and counter width are parameters.
- hs/vs/active_nblank are delayed by a configurable number of stages to match the colour pipeline latency.
- Game logic (ball, tetris) gets single-cycle enables instead of being clocked from vsync.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of hs (0 = active low)
VS_POL, 0, asserted level of vs
PIPE_DLY, 0, extra register stages on hs/vs/active_nblank (0..7)
CW, 10, width of drawX/drawY counters

Ports:
pixel_clk  in  1  pixel clock; all logic on rising edge
reset_rtl_0  in  1  synchronous, active-low reset
hs  out  1  horizontal sync, polarity HS_POL
vs  out  1  vertical sync, polarity VS_POL
active_nblank  out  1  high during visible region
drawX  out  CW  horizontal counter (current pixel column)
drawY  out  CW  vertical counter (current line)
line_start  out  1  one-cycle pulse when drawX==0
frame_start  out  1  one-cycle pulse when drawX==0 and drawY==0
vblank_tick  out  1  one-cycle pulse when drawX==0 and drawY==V_ACTIVE; game-update strobe
frame_cnt  out  8  frames completed (exists only with VGA_FRAME_CNT_EN)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise (defaults 800 and 525).
- Elaboration error if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CW-1, or if PIPE_DLY > 7.
- Counters:
  - drawX increments every cycle; at H_TOTAL-1 it wraps to 0.
  - drawY increments only when drawX wraps; at V_TOTAL-1 with drawX==H_TOTAL-1, both wrap to 0.
  - Counters run through blanking, with no stall.
- Decode (combinational, from counters):
  - hs_raw = HS_POL when H_ACTIVE+H_FP <= drawX < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vs_raw uses the same rule on drawY with the V parameters.
  - act_raw = (drawX < H_ACTIVE) && (drawY < V_ACTIVE).
- Latency:
  - drawX, drawY, line_start, frame_start and vblank_tick are aligned with the counters (latency 0).
  - Pulses are combinational compares of the registered counters.
  - hs, vs and active_nblank are registered: they reflect the raw decode of a counter value exactly PIPE_DLY+1 cycles later.
- Reset (reset_rtl_0 == 0 at a clock edge):
  - drawX = drawY = 0.
  - All delay stages load the inactive values: hs = ~HS_POL, vs = ~VS_POL, active_nblank = 0.
  - frame_cnt = 0.
  - Pulses are suppressed (0) while reset is held.
- Reset mid-frame: takes effect on the next edge. The first cycle after release is drawX=0, drawY=0 with frame_start=1. The delay pipeline flushes inactive values for PIPE_DLY+1 cycles.
- No output glitches: every sync/active output comes directly from a flop.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - 8-bit frame_cnt increments on the cycle after frame_start (i.e. counts completed frames) and wraps 255->0.
  - Reset value 0.
- Undefined:
  - frame_cnt port and its flops are absent.
  - All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 default constants (H_ACTIVE_640 ... V_BP_480);
  - localparam function for total computation;
  - typedef struct packed {hs, vs, act} sync_bus_t used by the delay line.
- Sub-module sync_delay_line (params DEPTH, RST_VAL of type sync_bus_t):
  - shift register with synchronous active-low reset;
  - DEPTH = PIPE_DLY+1.

Test Plan:
1. Defaults, hold reset 3 cycles then release -> cycle 0: drawX=0, drawY=0, frame_start=1, hs=1, vs=1, active_nblank=0; next cycle active_nblank=1.
2. Defaults, run one line -> hs low for exactly 96 cycles, first seen one cycle after drawX==656; drawX 799->0 with drawY 0->1 and line_start=1.
3. Defaults, run full frame -> vblank_tick exactly once at (0,480); vs low for lines 490-491; drawY 524->0 after 420000 cycles with frame_start=1.
4. PIPE_DLY=2 -> active_nblank rises 3 cycles after drawX==0 on line 0; hs falls 3 cycles after drawX==656.
5. Small timing (H 8/1/2/1, V 4/1/1/1, CW=4, HS_POL=1):
   - exhaustive compare against a reference model over 3 frames;
   - assert reset at drawX=5, drawY=2 -> next cycle counters 0,0 and hs=0.
6. VGA_FRAME_CNT_EN defined, small timing, 257 frames -> frame_cnt reads 1 after frame 257 (wraps through 0); undefined -> port absent, build succeeds.
